// File: rtl/stack_pkg.sv
// Shared types and defaults for the operand-stack controller.
package stack_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PUSH_WR,
      POP_RD,
      POP_FILL,
      DONE
   } state_t;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DEPTH  = 16;
   localparam int DEF_BASE   = 16;

   // sp counts entries, so it must represent 0..depth inclusive.
   function automatic int sp_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/stack_mem_ctrl_if.sv
// Command/response and data-memory signals of the operand-stack controller.
interface stack_mem_ctrl_if
   import stack_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int SP_W   = sp_width(DEF_DEPTH)
);

   // Command handshake: a push/pop/tos pulse is taken only while busy is low;
   // done pulses for one cycle when it finishes, with err when it was rejected.
   logic              push;
   logic              pop;
   logic              tos;
   logic [DATA_W-1:0] d_in;
   logic [DATA_W-1:0] d_out;
   logic              busy;
   logic              done;
   logic              err;
   logic              overflow;
   logic              underflow;
   logic [SP_W-1:0]   sp;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_write;
   logic              mem_read;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  push, pop, tos, d_in, mem_rdata,
      output d_out, busy, done, err, overflow, underflow, sp,
             mem_addr, mem_wdata, mem_write, mem_read
   );

   modport master (
      output push, pop, tos, d_in, mem_rdata,
      input  d_out, busy, done, err, overflow, underflow, sp,
             mem_addr, mem_wdata, mem_write, mem_read
   );

endinterface

// File: rtl/stack_ptr.sv
// Saturating entry counter for the operand stack.
module stack_ptr
   import stack_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int SP_W  = sp_width(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inc,
   input  logic            dec,
   output logic [SP_W-1:0] count,
   output logic            full,
   output logic            empty
);

   assign full  = (count == SP_W'(DEPTH));
   assign empty = (count == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && !dec && !full) begin
         count <= count + SP_W'(1);
      end else if (dec && !inc && !empty) begin
         count <= count - SP_W'(1);
      end
   end

endmodule

// File: rtl/stack_mem_ctrl.sv
// Operand-stack sequencer: owns sp, caches top-of-stack in tos_q and keeps
// the remaining entries in a synchronous data memory starting at BASE.
module stack_mem_ctrl
   import stack_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int BASE   = DEF_BASE
) (
   input  logic             clk,
   input  logic             rst,
   stack_mem_ctrl_if.slave  bus,
   output state_t           dbg_state
);

   localparam int SP_W = sp_width(DEPTH);
   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

   state_t            state;
   logic [DATA_W-1:0] tos_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] d_out_q;
   logic [DATA_W-1:0] wdata_q;
   logic [ADDR_W-1:0] addr_q;
   logic              done_q;
   logic              err_q;
   logic              ovf_q;
   logic              unf_q;
   logic              rd_q;
   logic              wr_q;

   logic [SP_W-1:0]   sp;
   logic              full;
   logic              empty;
   logic              sp_one;
   logic [ADDR_W-1:0] sp_a;

   stack_ptr #(.DEPTH(DEPTH), .SP_W(SP_W)) u_ptr (
      .clk   (clk),
      .rst   (rst),
      .inc   (state == PUSH_WR),
      .dec   (state == POP_RD),
      .count (sp),
      .full  (full),
      .empty (empty)
   );

   assign sp_one = (sp == SP_W'(1));
   assign sp_a   = ADDR_W'(sp);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         tos_q   <= '0;
         data_q  <= '0;
         d_out_q <= '0;
         wdata_q <= '0;
         addr_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               err_q  <= 1'b0;
               if (bus.push) begin
                  data_q <= bus.d_in;
                  if (full) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                     err_q  <= 1'b1;
                     ovf_q  <= 1'b1;
                  end else begin
                     state   <= PUSH_WR;
                     wr_q    <= 1'b1;
                     addr_q  <= BASE_A + sp_a;
                     wdata_q <= bus.d_in;
                  end
               end else if (bus.pop) begin
                  if (empty) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                     err_q  <= 1'b1;
                     unf_q  <= 1'b1;
                  end else begin
                     state <= POP_RD;
                     // The new top lives in memory only when two or more entries exist.
                     if (!sp_one) begin
                        rd_q   <= 1'b1;
                        addr_q <= BASE_A + sp_a - ADDR_W'(2);
                     end
                  end
               end else if (bus.tos) begin
                  state  <= DONE;
                  done_q <= 1'b1;
                  if (empty) begin
                     err_q <= 1'b1;
                     unf_q <= 1'b1;
                  end else begin
                     d_out_q <= tos_q;
                  end
               end
            end
            PUSH_WR: begin
               wr_q   <= 1'b0;
               tos_q  <= data_q;
               state  <= DONE;
               done_q <= 1'b1;
            end
            POP_RD: begin
               rd_q    <= 1'b0;
               d_out_q <= tos_q;
               if (sp_one) begin
                  tos_q  <= '0;
                  state  <= DONE;
                  done_q <= 1'b1;
               end else begin
                  state <= POP_FILL;
               end
            end
            POP_FILL: begin
               tos_q  <= bus.mem_rdata;
               state  <= DONE;
               done_q <= 1'b1;
            end
            DONE: begin
               done_q <= 1'b0;
               err_q  <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.d_out     = d_out_q;
   assign bus.busy      = (state != IDLE);
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;
   assign bus.sp        = sp;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   // A write still pending when reset arrives must not reach memory.
   assign bus.mem_write = wr_q & ~rst;
   assign bus.mem_read  = rd_q;
   assign dbg_state     = state;

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Directed bench for stack_mem_ctrl with a synchronous memory model.
module tb_stack_mem_ctrl;
   import stack_pkg::*;

   localparam int SP_W = sp_width(DEF_DEPTH);

   logic   clk = 1'b0;
   logic   rst = 1'b1;
   state_t dbg_state;

   stack_mem_ctrl_if #(.DATA_W(8), .ADDR_W(5), .SP_W(SP_W)) bus ();

   stack_mem_ctrl #(.DATA_W(8), .ADDR_W(5), .DEPTH(16), .BASE(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // synchronous memory: read data appears the cycle after mem_read
   logic [7:0] mem [0:31];
   always @(posedge clk) begin
      if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_read)  bus.mem_rdata <= mem[bus.mem_addr];
   end

   int         wr_cnt = 0;
   int         rd_cnt = 0;
   int         both_cnt = 0;
   logic [4:0] wr_addr_log [64];
   logic [7:0] wr_data_log [64];
   logic [4:0] rd_addr_log [64];

   always @(negedge clk) begin
      if (bus.mem_write && wr_cnt < 64) begin
         wr_addr_log[wr_cnt] = bus.mem_addr;
         wr_data_log[wr_cnt] = bus.mem_wdata;
         wr_cnt++;
      end
      if (bus.mem_read && rd_cnt < 64) begin
         rd_addr_log[rd_cnt] = bus.mem_addr;
         rd_cnt++;
      end
      if (bus.mem_read && bus.mem_write) both_cnt++;
   end

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q [$];
   int         lat;
   logic       e;
   int         w0;
   int         r0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One command pulse; returns cycles from accept edge to done, and err.
   task automatic run_cmd(input logic p, input logic po, input logic t,
                          input logic [7:0] d, output int l, output logic er);
      @(negedge clk);
      bus.push = p; bus.pop = po; bus.tos = t; bus.d_in = d;
      @(negedge clk);
      bus.push = 1'b0; bus.pop = 1'b0; bus.tos = 1'b0;
      l = 1;
      while (!bus.done && l < 8) begin
         @(negedge clk);
         l++;
      end
      check("done_seen", bus.done, 1);
      er = bus.err;
   endtask

   task automatic do_push(input logic [7:0] d, input string tag);
      run_cmd(1'b1, 1'b0, 1'b0, d, lat, e);
      check({tag, "_lat"}, lat, 2);
      check({tag, "_err"}, e, 0);
      exp_q.push_back(d);
   endtask

   task automatic do_pop(input int exp_lat, input string tag);
      logic [7:0] v;
      run_cmd(1'b0, 1'b1, 1'b0, 8'h00, lat, e);
      v = exp_q.pop_back();
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_err"}, e, 0);
      check({tag, "_dout"}, bus.d_out, v);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.push = 1'b0; bus.pop = 1'b0; bus.tos = 1'b0; bus.d_in = 8'h00;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_sp", bus.sp, 0);
      check("rst_dout", bus.d_out, 0);
      check("rst_flags", {bus.done, bus.err, bus.overflow, bus.underflow, bus.busy}, 0);
      check("rst_mem", {bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata}, 0);
      rst = 1'b0;

      // three pushes land at consecutive addresses from BASE
      do_push(8'h11, "push11");
      do_push(8'h22, "push22");
      do_push(8'h33, "push33");
      check("push_wr_cnt", wr_cnt, 3);
      check("push_addr0", wr_addr_log[0], 16);
      check("push_addr1", wr_addr_log[1], 17);
      check("push_addr2", wr_addr_log[2], 18);
      check("push_data2", wr_data_log[2], 8'h33);
      check("push_sp", bus.sp, 3);

      r0 = rd_cnt;
      do_pop(3, "pop33");
      do_pop(3, "pop22");
      do_pop(2, "pop11");
      check("pop_rd_cnt", rd_cnt - r0, 2);
      check("pop_rd_addr0", rd_addr_log[r0], 17);
      check("pop_rd_addr1", rd_addr_log[r0 + 1], 16);
      check("pop_sp", bus.sp, 0);

      // tos reads the cached top without touching memory
      do_push(8'h5A, "push5a");
      do_push(8'hA5, "pusha5");
      w0 = wr_cnt; r0 = rd_cnt;
      run_cmd(1'b0, 1'b0, 1'b1, 8'h00, lat, e);
      check("tos_lat", lat, 1);
      check("tos_err", e, 0);
      check("tos_dout", bus.d_out, 8'hA5);
      check("tos_sp", bus.sp, 2);
      check("tos_nomem", {wr_cnt - w0, rd_cnt - r0}, 0);
      do_pop(3, "popa5");
      do_pop(2, "pop5a");

      // underflow is sticky and does not disturb d_out
      run_cmd(1'b0, 1'b1, 1'b0, 8'h00, lat, e);
      check("unf_lat", lat, 1);
      check("unf_err", e, 1);
      check("unf_flag", bus.underflow, 1);
      check("unf_dout", bus.d_out, 8'h5A);
      do_push(8'h01, "push01");
      check("unf_sticky", bus.underflow, 1);
      check("unf_sp", bus.sp, 1);

      for (int i = 2; i <= 16; i++) do_push(8'h80 + 8'(i), "fill");
      check("full_sp", bus.sp, 16);
      w0 = wr_cnt;
      run_cmd(1'b1, 1'b0, 1'b0, 8'hFF, lat, e);
      check("ovf_lat", lat, 1);
      check("ovf_err", e, 1);
      check("ovf_flag", bus.overflow, 1);
      check("ovf_nowr", wr_cnt - w0, 0);
      check("ovf_sp", bus.sp, 16);
      check("ovf_addr", bus.mem_addr, 31);
      do_pop(3, "pop90");
      check("pop90_rd_addr", rd_addr_log[rd_cnt - 1], 30);
      check("pop90_sp", bus.sp, 15);

      // push wins over a simultaneous pop
      run_cmd(1'b1, 1'b1, 1'b0, 8'hC3, lat, e);
      check("prio_lat", lat, 2);
      check("prio_err", e, 0);
      check("prio_sp", bus.sp, 16);
      check("prio_addr", wr_addr_log[wr_cnt - 1], 31);
      exp_q.push_back(8'hC3);
      do_pop(3, "popc3");

      // pop pulse during PUSH_WR is ignored
      @(negedge clk);
      bus.push = 1'b1; bus.d_in = 8'h3C;
      @(negedge clk);
      bus.push = 1'b0; bus.pop = 1'b1;
      check("busy_state", dbg_state, PUSH_WR);
      @(negedge clk);
      bus.pop = 1'b0;
      check("busy_done", bus.done, 1);
      @(negedge clk);
      check("busy_idle", dbg_state, IDLE);
      check("busy_sp", bus.sp, 16);
      check("busy_flag", bus.busy, 0);
      exp_q.push_back(8'h3C);

      // reset during POP_FILL
      @(negedge clk);
      bus.pop = 1'b1;
      @(negedge clk);
      bus.pop = 1'b0;
      @(negedge clk);
      check("fill_state", dbg_state, POP_FILL);
      rst = 1'b1;
      @(negedge clk);
      check("arst_sp", bus.sp, 0);
      check("arst_dout", bus.d_out, 0);
      check("arst_flags", {bus.done, bus.err, bus.overflow, bus.underflow, bus.busy}, 0);
      check("arst_mem", {bus.mem_read, bus.mem_addr, bus.mem_wdata}, 0);
      check("arst_state", dbg_state, IDLE);
      rst = 1'b0;
      exp_q.delete();

      // reset during PUSH_WR suppresses the write
      @(negedge clk);
      bus.push = 1'b1; bus.d_in = 8'hEE;
      @(negedge clk);
      bus.push = 1'b0;
      check("wrst_state", dbg_state, PUSH_WR);
      #1 rst = 1'b1;
      #1 check("wrst_nowrite", bus.mem_write, 0);
      @(negedge clk);
      rst = 1'b0;
      check("wrst_mem16", mem[16], 8'h01);
      check("wrst_sp", bus.sp, 0);

      run_cmd(1'b0, 1'b0, 1'b1, 8'h00, lat, e);
      check("tos_empty_err", e, 1);
      check("tos_empty_unf", bus.underflow, 1);
      do_push(8'h42, "push42");
      run_cmd(1'b0, 1'b0, 1'b1, 8'h00, lat, e);
      check("tos42_dout", bus.d_out, 8'h42);
      check("tos42_lat", lat, 1);
      check("no_rw_overlap", both_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stack_mem_ctrl.md
Name: stack_mem_ctrl

Overview:
- Sequences the operand stack of the multi-cycle stack machine.
- Stack entries live in a dedicated region of a synchronous data memory; the controller owns the stack pointer and keeps a cached top-of-stack register.
- Serves single-cycle push/pop/tos command pulses from the control unit and returns data to the datapath.
- Raises done when each command completes, and flags overflow/underflow.

Parameters:
- DATA_W, 8, stack word width (matches datapath d_out).
- ADDR_W, 5, memory address width.
- DEPTH, 16, maximum number of stack entries.
- BASE, 16, memory address of entry 0; requires BASE+DEPTH <= 2**ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- push  in  1  push command pulse; data on d_in.
- pop  in  1  pop command pulse.
- tos  in  1  read top-of-stack without removal.
- d_in  in  DATA_W  push data.
- d_out  out  DATA_W  popped / top value; valid when done=1, held until the next pop/tos completes.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse with done when a command was rejected.
- overflow  out  1  sticky; cleared only by rst.
- underflow  out  1  sticky; cleared only by rst.
- sp  out  clog2(DEPTH+1)  current entry count.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_write  out  1  memory write strobe.
- mem_read  out  1  memory read strobe; mem_rdata is valid the following cycle.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset values: state=IDLE; sp=0; tos_q=0; d_out=0; done=err=overflow=underflow=0; mem_read=mem_write=0; mem_addr=0; mem_wdata=0.
- Commands are sampled only in IDLE. Commands arriving while busy are ignored; the CU must wait for done.
- Priority when more than one command is high: push > pop > tos.
- The IDLE accept cycle is T. d_in is latched into data_q at T.
- FSM states: IDLE, PUSH_WR, POP_RD, POP_FILL, DONE.
- Push, sp<DEPTH:
  - T+1 PUSH_WR: mem_write=1, mem_addr=BASE+sp, mem_wdata=data_q; sp<=sp+1; tos_q<=data_q.
  - T+2 DONE: done=1.
- Push, sp==DEPTH: T+1 DONE with done=err=1 and overflow<=1. No memory access; sp and tos_q unchanged.
- Pop, sp>=2:
  - T+1 POP_RD: d_out<=tos_q; sp<=sp-1; mem_read=1, mem_addr=BASE+sp-2.
  - T+2 POP_FILL: tos_q<=mem_rdata.
  - T+3 DONE: done=1.
- Pop, sp==1: T+1 POP_RD with d_out<=tos_q, sp<=0, tos_q<=0, no mem_read. T+2 DONE.
- Pop or tos with sp==0: T+1 DONE with done=err=1 and underflow<=1. d_out unchanged.
- Tos, sp>=1: d_out<=tos_q at the T edge; T+1 DONE, done=1. No memory access.
- DONE always returns to IDLE next cycle, so the minimum command spacing is 2 cycles.
- mem_read and mem_write are never high together, and are low outside PUSH_WR/POP_RD.
- mem_addr and mem_wdata hold their last values when unused.
- sp never leaves [0, DEPTH]; there is no wrap-around.
- rst mid-command aborts immediately to reset values. A memory write in the reset cycle is suppressed.

Decomposition:
- Shared package stack_pkg holds:
  - the state enum;
  - default DATA_W/ADDR_W/DEPTH/BASE constants;
  - a function computing the sp width.
- One sub-module, stack_ptr: up/down counter with inc/dec inputs and full/empty outputs, parameterised by DEPTH.
- The FSM, tos_q, and memory muxing stay in stack_mem_ctrl.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 → three writes at addresses 16/17/18; sp=3; done 2 cycles after each accept.
- Pop ×3 after that → d_out 0x33, 0x22, 0x11. Reads at addresses 17 and 16 only; the third pop does no read; sp=0.
- Tos with sp=2 (top=0xA5) → d_out=0xA5 with done at T+1, sp unchanged, no mem strobes.
- Pop with sp=0 → done=err=1 at T+1, underflow=1 and stays set; d_out unchanged. Then push 0x01 → succeeds, underflow still 1.
- Push 17 times with DEPTH=16 → the 17th gives err=1, overflow=1, no mem_write, sp=16. Then pop → 16th value returned.
- push=pop=1 together in IDLE → push executes. A pop pulse during a PUSH_WR cycle is ignored. Assert rst during POP_FILL → all outputs return to reset values next cycle.
